// File: rtl/vend_ctrl.sv
// Vending-machine controller: credits coins, pulses dispense at PRICE, returns change one coin at a time.
// Optional idle auto-refund is compiled in when VEND_TIMEOUT_EN is defined.
module vend_ctrl #(
    parameter int PRICE       = 15,
    parameter int CREDIT_W    = 7,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                coin_valid,
    input  logic [1:0]          coin_sel,
    input  logic                cancel,
    output logic                coin_reject,
    output logic                dispense,
    output logic                chg_valid,
    output logic [1:0]          chg_sel,
    input  logic                chg_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic                timeout
);

    typedef enum logic [1:0] {
        COLLECT  = 2'd0,
        DISPENSE = 2'd1,
        CHANGE   = 2'd2
    } state_t;

    localparam logic [CREDIT_W-1:0] PRICE_C = CREDIT_W'(PRICE);

    // Elaboration-time sanity check of the configuration.
    if ((PRICE % 5) != 0 || PRICE < 5 || PRICE > 100 || TIMEOUT_CYC < 1 ||
        (PRICE + 20) >= (1 << CREDIT_W)) begin : g_bad_params
        $error("vend_ctrl: illegal PRICE/CREDIT_W/TIMEOUT_CYC combination");
    end

    function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] sel);
        case (sel)
            2'b01:   coin_value = CREDIT_W'(5);
            2'b10:   coin_value = CREDIT_W'(10);
            2'b11:   coin_value = CREDIT_W'(25);
            default: coin_value = '0;
        endcase
    endfunction

    function automatic logic [1:0] greedy_coin(input logic [CREDIT_W-1:0] c);
        if (c >= CREDIT_W'(25))      greedy_coin = 2'b11;
        else if (c >= CREDIT_W'(10)) greedy_coin = 2'b10;
        else                         greedy_coin = 2'b01;
    endfunction

    state_t                state_reg;
    logic                  coin_ok;
    logic                  expire;
    logic [CREDIT_W-1:0]   sum_next;
    logic [CREDIT_W-1:0]   remainder_next;
    logic [CREDIT_W-1:0]   after_chg_next;

    always_comb begin
        coin_ok        = coin_valid && (coin_sel != 2'b00);
        sum_next       = credit + (coin_ok ? coin_value(coin_sel) : '0);
        remainder_next = credit - PRICE_C;
        after_chg_next = credit - coin_value(chg_sel);
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_cnt_reg;

    // Counts idle COLLECT cycles while holding credit; expiry cycle is the TIMEOUT_CYC-th idle cycle.
    assign expire = (state_reg == COLLECT) && (credit != '0) &&
                    (tmo_cnt_reg == TW'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg != COLLECT || coin_ok || credit == '0 || expire) begin
            tmo_cnt_reg <= '0;
        end else begin
            tmo_cnt_reg <= tmo_cnt_reg + TW'(1);
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= COLLECT;
            credit      <= '0;
            coin_reject <= 1'b0;
            dispense    <= 1'b0;
            chg_valid   <= 1'b0;
            chg_sel     <= 2'b00;
            timeout     <= 1'b0;
        end else begin
            coin_reject <= 1'b0;
            dispense    <= 1'b0;
            timeout     <= 1'b0;
            case (state_reg)
                COLLECT: begin
                    credit <= sum_next;
                    if ((cancel || expire) && sum_next != '0) begin
                        // Full refund, including any coin accepted this cycle.
                        state_reg <= CHANGE;
                        chg_valid <= 1'b1;
                        chg_sel   <= greedy_coin(sum_next);
                        timeout   <= expire && !cancel;
                    end else if (sum_next >= PRICE_C) begin
                        state_reg <= DISPENSE;
                        dispense  <= 1'b1;
                    end
                end
                DISPENSE: begin
                    coin_reject <= coin_ok;
                    credit      <= remainder_next;
                    if (remainder_next != '0) begin
                        state_reg <= CHANGE;
                        chg_valid <= 1'b1;
                        chg_sel   <= greedy_coin(remainder_next);
                    end else begin
                        state_reg <= COLLECT;
                    end
                end
                CHANGE: begin
                    coin_reject <= coin_ok;
                    if (chg_ready) begin
                        credit <= after_chg_next;
                        if (after_chg_next == '0) begin
                            state_reg <= COLLECT;
                            chg_valid <= 1'b0;
                            chg_sel   <= 2'b00;
                        end else begin
                            chg_sel <= greedy_coin(after_chg_next);
                        end
                    end
                end
                default: begin
                    state_reg <= COLLECT;
                    chg_valid <= 1'b0;
                    chg_sel   <= 2'b00;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_ctrl.sv
// Directed self-checking bench for vend_ctrl at PRICE=15 (TIMEOUT_CYC=8 when VEND_TIMEOUT_EN is defined).
module tb_vend_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_valid = 1'b0;
    logic [1:0] coin_sel = 2'b00;
    logic       cancel = 1'b0;
    logic       chg_ready = 1'b0;
    logic       coin_reject;
    logic       dispense;
    logic       chg_valid;
    logic [1:0] chg_sel;
    logic [6:0] credit;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    vend_ctrl #(
        .PRICE       (15),
        .CREDIT_W    (7),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coin_valid  (coin_valid),
        .coin_sel    (coin_sel),
        .cancel      (cancel),
        .coin_reject (coin_reject),
        .dispense    (dispense),
        .chg_valid   (chg_valid),
        .chg_sel     (chg_sel),
        .chg_ready   (chg_ready),
        .credit      (credit),
        .timeout     (timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Advance one clock; outputs are then stable 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic insert_coin(input logic [1:0] sel);
        coin_valid = 1'b1;
        coin_sel   = sel;
        step();
        coin_valid = 1'b0;
        coin_sel   = 2'b00;
    endtask

    task automatic check_chg(input string tag, input int v, input int sel, input int cr);
        check({tag, "_chg_valid"}, int'(chg_valid), v);
        check({tag, "_chg_sel"}, int'(chg_sel), sel);
        check({tag, "_credit"}, int'(credit), cr);
    endtask

    initial begin
        #2;
        check("rst_credit", int'(credit), 0);
        check("rst_dispense", int'(dispense), 0);
        check_chg("rst", 0, 0, 0);
        check("rst_reject", int'(coin_reject), 0);
        check("rst_timeout", int'(timeout), 0);
        step();
        rst_n = 1'b1;
        step();

        // coin_valid with code 00 is ignored without reject
        insert_coin(2'b00);
        check("nocoin_credit", int'(credit), 0);
        check("nocoin_reject", int'(coin_reject), 0);

        // 1: dime then nickel -> exact price, no change
        insert_coin(2'b10);
        check("t1_credit10", int'(credit), 10);
        check("t1_no_disp", int'(dispense), 0);
        insert_coin(2'b01);
        check("t1_dispense", int'(dispense), 1);
        check("t1_credit15", int'(credit), 15);
        step();
        check("t1_disp_drop", int'(dispense), 0);
        check_chg("t1_after", 0, 0, 0);
        step();
        check("t1_idle_valid", int'(chg_valid), 0);

        // 2: quarter with hopper stalled for 3 cycles
        chg_ready = 1'b0;
        insert_coin(2'b11);
        check("t2_dispense", int'(dispense), 1);
        check("t2_credit25", int'(credit), 25);
        step();
        check_chg("t2_stall0", 1, 2, 10);
        check("t2_disp_drop", int'(dispense), 0);
        step();
        check_chg("t2_stall1", 1, 2, 10);
        step();
        check_chg("t2_stall2", 1, 2, 10);
        chg_ready = 1'b1;
        step();
        check_chg("t2_done", 0, 0, 0);
        chg_ready = 1'b0;

        // 3: nickel, then dime together with cancel -> full refund 15
        insert_coin(2'b01);
        check("t3_credit5", int'(credit), 5);
        coin_valid = 1'b1;
        coin_sel   = 2'b10;
        cancel     = 1'b1;
        step();
        coin_valid = 1'b0;
        coin_sel   = 2'b00;
        cancel     = 1'b0;
        check("t3_no_disp", int'(dispense), 0);
        check_chg("t3_refund0", 1, 2, 15);
        chg_ready = 1'b1;
        step();
        check_chg("t3_refund1", 1, 1, 5);
        check("t3_no_disp2", int'(dispense), 0);
        step();
        check_chg("t3_done", 0, 0, 0);
        chg_ready = 1'b0;

        // 4: coin during CHANGE is rejected, change continues
        insert_coin(2'b11);
        check("t4_dispense", int'(dispense), 1);
        step();
        check_chg("t4_chg", 1, 2, 10);
        insert_coin(2'b11);
        check("t4_reject", int'(coin_reject), 1);
        check_chg("t4_hold", 1, 2, 10);
        step();
        check("t4_reject_drop", int'(coin_reject), 0);
        check("t4_credit", int'(credit), 10);
        chg_ready = 1'b1;
        step();
        check_chg("t4_done", 0, 0, 0);
        chg_ready = 1'b0;

        // 5: asynchronous reset mid-CHANGE discards outstanding change
        insert_coin(2'b11);
        step();
        check_chg("t5_pre", 1, 2, 10);
        rst_n = 1'b0;
        #1;
        check_chg("t5_async", 0, 0, 0);
        step();
        rst_n = 1'b1;
        step();
        check_chg("t5_post", 0, 0, 0);
        insert_coin(2'b10);
        insert_coin(2'b01);
        check("t5_buy_disp", int'(dispense), 1);
        step();
        check_chg("t5_buy_after", 0, 0, 0);

        // 6: idle credit -> auto-refund only when the timeout feature is built in
        insert_coin(2'b01);
        check("t6_credit5", int'(credit), 5);
        for (int i = 0; i < 7; i++) step();
`ifdef VEND_TIMEOUT_EN
        check("t6_pre_timeout", int'(timeout), 0);
        check("t6_pre_valid", int'(chg_valid), 0);
        step();
        check("t6_timeout", int'(timeout), 1);
        check_chg("t6_refund", 1, 1, 5);
        step();
        check("t6_timeout_drop", int'(timeout), 0);
        chg_ready = 1'b1;
        step();
        check_chg("t6_done", 0, 0, 0);
        chg_ready = 1'b0;
`else
        step();
        check("t6_no_timeout", int'(timeout), 0);
        check_chg("t6_held", 0, 0, 5);
        for (int i = 0; i < 20; i++) step();
        check("t6_still_held", int'(credit), 5);
        cancel = 1'b1;
        step();
        cancel = 1'b0;
        check_chg("t6_cancel", 1, 1, 5);
        chg_ready = 1'b1;
        step();
        check_chg("t6_done", 0, 0, 0);
        chg_ready = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
